rob_multiport: RTL and testbench

Parametrised reorder buffer for the out-of-order core. Sits between rename/dispatch and the physical register file / free list.
- Allocates up to DISPATCH_W entries per cycle in program order.
- Accepts up to COMPLETE_W out-of-order completions per cycle.
- Retires up to RETIRE_W oldest completed entries per cycle, in order.
- Supports a branch-mispredict flush that squashes every entry younger than a given index.

---
 rtl/rob_multiport.sv | 193 +++++++++++++++++++
 tb/tb_rob_multiport.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Multi-lane reorder buffer: in-order allocate, out-of-order complete, in-order retire.
// Supports a branch-mispredict flush that keeps the oldest entries up to a given index.
module rob_multiport #(
  parameter int PC_SIZE        = 32,
  parameter int WORD_SIZE      = 32,
  parameter int NUM_P_REGS     = 64,
  parameter int CONTR_SIG_SIZE = 5,
  parameter int ROB_SIZE       = 16,
  parameter int DISPATCH_W     = 2,
  parameter int COMPLETE_W     = 3,
  parameter int RETIRE_W       = 2,
  localparam int PW = $clog2(NUM_P_REGS),
  localparam int IW = $clog2(ROB_SIZE)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [DISPATCH_W-1:0]                disp_en_i,
  input  logic [DISPATCH_W*PW-1:0]             disp_dest_i,
  input  logic [DISPATCH_W*PW-1:0]             disp_old_dest_i,
  input  logic [DISPATCH_W*CONTR_SIG_SIZE-1:0] disp_contr_i,
  input  logic [DISPATCH_W*PC_SIZE-1:0]        disp_pc_i,
  output logic                                 disp_ready_o,
  output logic [DISPATCH_W*IW-1:0]             disp_indx_o,
  input  logic [COMPLETE_W-1:0]                cmpl_en_i,
  input  logic [COMPLETE_W*IW-1:0]             cmpl_indx_i,
  input  logic [COMPLETE_W*PC_SIZE-1:0]        cmpl_pc_i,
  input  logic [COMPLETE_W*WORD_SIZE-1:0]      cmpl_val_i,
  output logic [RETIRE_W-1:0]                  ret_en_o,
  output logic [RETIRE_W*PW-1:0]               ret_dest_o,
  output logic [RETIRE_W*PW-1:0]               ret_old_dest_o,
  output logic [RETIRE_W*WORD_SIZE-1:0]        ret_val_o,
  output logic [RETIRE_W*PC_SIZE-1:0]          ret_pc_o,
  input  logic                                 flush_i,
  input  logic [IW-1:0]                        flush_indx_i,
  output logic [IW:0]                          count_o,
  output logic                                 empty_o,
  output logic                                 err_o
);

  logic [IW-1:0]             head, tail;
  logic [IW:0]               count;
  logic [ROB_SIZE-1:0]       valid, complete;
  logic                      err;

  logic [PW-1:0]             dest_mem  [ROB_SIZE];
  logic [PW-1:0]             old_mem   [ROB_SIZE];
  logic [CONTR_SIG_SIZE-1:0] contr_mem [ROB_SIZE];
  logic [PC_SIZE-1:0]        pc_mem    [ROB_SIZE];
  logic [WORD_SIZE-1:0]      val_mem   [ROB_SIZE];

  // Control bits travel with the entry but nothing downstream consumes them here.
  logic contr_unused;
  assign contr_unused = ^contr_mem[head];

  // ---------------- dispatch ----------------
  logic [IW-1:0] disp_slot [DISPATCH_W];
  logic [IW:0]   disp_num;
  logic          disp_fire;

  assign disp_ready_o = ({1'b0, count} + (IW+2)'(DISPATCH_W)) <= (IW+2)'(ROB_SIZE);
  assign disp_fire    = disp_ready_o && !flush_i;

  // Enabled lanes are packed onto consecutive slots starting at tail.
  always_comb begin
    disp_num = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_slot[k] = tail + disp_num[IW-1:0];
      disp_num     = disp_num + (IW+1)'(disp_en_i[k]);
    end
  end

  generate
    for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_disp_indx
      assign disp_indx_o[gi*IW +: IW] = disp_slot[gi];
    end
  endgenerate

  // ---------------- flush ----------------
  logic                flush_ok;
  logic [IW-1:0]       flush_span;
  logic [ROB_SIZE-1:0] squash;

  assign flush_ok   = flush_i && valid[flush_indx_i];
  assign flush_span = flush_indx_i - head;

  generate
    for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_squash
      assign squash[gi] = flush_ok && valid[gi] && ((IW'(gi) - head) > flush_span);
    end
  endgenerate

  // ---------------- retire ----------------
  logic [IW-1:0] ret_slot [RETIRE_W];
  logic [IW:0]   ret_num;
  logic          ret_go;

  always_comb begin
    ret_go         = 1'b1;
    ret_num        = '0;
    ret_en_o       = '0;
    ret_dest_o     = '0;
    ret_old_dest_o = '0;
    ret_val_o      = '0;
    ret_pc_o       = '0;
    for (int r = 0; r < RETIRE_W; r++) begin
      ret_slot[r] = head + IW'(r);
      // A flush never lets anything younger than the surviving index retire.
      ret_go = ret_go && valid[ret_slot[r]] && complete[ret_slot[r]] &&
               (!flush_ok || (IW'(r) <= flush_span));
      ret_en_o[r] = ret_go;
      ret_num     = ret_num + (IW+1)'(ret_go);
      ret_dest_o[r*PW +: PW]               = dest_mem[ret_slot[r]];
      ret_old_dest_o[r*PW +: PW]           = old_mem[ret_slot[r]];
      ret_val_o[r*WORD_SIZE +: WORD_SIZE]  = val_mem[ret_slot[r]];
      ret_pc_o[r*PC_SIZE +: PC_SIZE]       = pc_mem[ret_slot[r]];
    end
  end

  // ---------------- completion ----------------
  logic [IW-1:0]         cmpl_slot [COMPLETE_W];
  logic [COMPLETE_W-1:0] cmpl_hit, cmpl_ok, cmpl_bad;

  generate
    for (genvar gi = 0; gi < COMPLETE_W; gi++) begin : g_cmpl
      assign cmpl_slot[gi] = cmpl_indx_i[gi*IW +: IW];
      assign cmpl_hit[gi]  = valid[cmpl_slot[gi]] &&
                             (pc_mem[cmpl_slot[gi]] == cmpl_pc_i[gi*PC_SIZE +: PC_SIZE]);
      assign cmpl_ok[gi]   = cmpl_en_i[gi] && !squash[cmpl_slot[gi]] && cmpl_hit[gi];
      assign cmpl_bad[gi]  = cmpl_en_i[gi] && !squash[cmpl_slot[gi]] && !cmpl_hit[gi];
    end
  endgenerate

  // ---------------- state update ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
      err      <= 1'b0;
    end else begin
      for (int k = 0; k < COMPLETE_W; k++)
        if (cmpl_ok[k]) complete[cmpl_slot[k]] <= 1'b1;
      for (int r = 0; r < RETIRE_W; r++)
        if (ret_en_o[r]) begin
          valid[ret_slot[r]]    <= 1'b0;
          complete[ret_slot[r]] <= 1'b0;
        end
      for (int i = 0; i < ROB_SIZE; i++)
        if (squash[i]) begin
          valid[i]    <= 1'b0;
          complete[i] <= 1'b0;
        end
      if (disp_fire)
        for (int k = 0; k < DISPATCH_W; k++)
          if (disp_en_i[k]) begin
            valid[disp_slot[k]]    <= 1'b1;
            complete[disp_slot[k]] <= 1'b0;
          end

      head <= head + ret_num[IW-1:0];
      if (flush_ok) begin
        tail  <= flush_indx_i + 1'b1;
        count <= {1'b0, flush_span} + (IW+1)'(1) - ret_num;
      end else if (disp_fire) begin
        tail  <= tail + disp_num[IW-1:0];
        count <= count + disp_num - ret_num;
      end else begin
        count <= count - ret_num;
      end
      err <= err | (|cmpl_bad) | (flush_i && !valid[flush_indx_i]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < COMPLETE_W; k++)
      if (cmpl_ok[k]) val_mem[cmpl_slot[k]] <= cmpl_val_i[k*WORD_SIZE +: WORD_SIZE];
    if (disp_fire)
      for (int k = 0; k < DISPATCH_W; k++)
        if (disp_en_i[k]) begin
          dest_mem[disp_slot[k]]  <= disp_dest_i[k*PW +: PW];
          old_mem[disp_slot[k]]   <= disp_old_dest_i[k*PW +: PW];
          contr_mem[disp_slot[k]] <= disp_contr_i[k*CONTR_SIG_SIZE +: CONTR_SIG_SIZE];
          pc_mem[disp_slot[k]]    <= disp_pc_i[k*PC_SIZE +: PC_SIZE];
        end
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign err_o   = err;

endmodule

// File: tb/tb_rob_multiport.sv
// Randomised scoreboard bench for rob_multiport: an in-order queue of expected
// retirements is built at dispatch, edited by completion/flush, and drained by a monitor.
module tb_rob_multiport;
  logic        clk, rst_n;
  logic [1:0]  disp_en;
  logic [11:0] disp_dest, disp_old_dest;
  logic [9:0]  disp_contr;
  logic [63:0] disp_pc;
  logic        disp_ready;
  logic [7:0]  disp_indx;
  logic [2:0]  cmpl_en;
  logic [11:0] cmpl_indx;
  logic [95:0] cmpl_pc, cmpl_val;
  logic [1:0]  ret_en;
  logic [11:0] ret_dest, ret_old_dest;
  logic [63:0] ret_val, ret_pc;
  logic        flush;
  logic [3:0]  flush_indx;
  logic [4:0]  count;
  logic        empty, err;

  rob_multiport dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .disp_en_i(disp_en), .disp_dest_i(disp_dest), .disp_old_dest_i(disp_old_dest),
    .disp_contr_i(disp_contr), .disp_pc_i(disp_pc),
    .disp_ready_o(disp_ready), .disp_indx_o(disp_indx),
    .cmpl_en_i(cmpl_en), .cmpl_indx_i(cmpl_indx), .cmpl_pc_i(cmpl_pc), .cmpl_val_i(cmpl_val),
    .ret_en_o(ret_en), .ret_dest_o(ret_dest), .ret_old_dest_o(ret_old_dest),
    .ret_val_o(ret_val), .ret_pc_o(ret_pc),
    .flush_i(flush), .flush_indx_i(flush_indx),
    .count_o(count), .empty_o(empty), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [5:0]  dest;
    logic [5:0]  old;
    logic [31:0] val;
    bit          done;
    int          done_cyc;
  } ent_t;

  ent_t sb_q[$];      // program-order list of live entries
  int   m_head = 0;   // ROB index of sb_q[0]
  bit   err_exp = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    disp_en = '0; disp_dest = '0; disp_old_dest = '0; disp_contr = '0; disp_pc = '0;
    cmpl_en = '0; cmpl_indx = '0; cmpl_pc = '0; cmpl_val = '0;
    flush = 1'b0; flush_indx = '0;
  endtask

  // One clock of stimulus; percentages steer dispatch, completion, flush and bad completions.
  task automatic do_cycle(input int dp, input int cp, input int fp, input int bp);
    int   size0, tail0, p, pos, kind, idx, en_below;
    bit   fl, fok;
    bit   used[16];
    int   cand[$];
    ent_t e;
    logic [31:0] v;
    @(posedge clk); #1;
    cyc++;
    size0 = sb_q.size();
    tail0 = (m_head + size0) % 16;
    check("count", 64'(count), 64'(size0));
    check("empty", 64'(empty), 64'(size0 == 0));
    check("disp_ready", 64'(disp_ready), 64'((16 - size0) >= 2));
    check("err", 64'(err), 64'(err_exp));
    clear_inputs();
    for (int i = 0; i < 16; i++) used[i] = 0;

    fl = 0; fok = 0; p = -1;
    if ($urandom_range(99) < fp) begin
      fl = 1;
      if (size0 > 0 && (size0 == 16 || $urandom_range(3) != 0)) begin
        p = $urandom_range(size0 - 1);
        flush_indx = 4'(sb_q[p].idx);
        fok = 1;
      end else begin
        flush_indx = 4'((tail0 + $urandom_range(15 - size0)) % 16);
      end
    end
    flush = fl;

    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(99) < cp) begin
        kind = $urandom_range(99);
        v = $urandom;
        if (kind < bp && (kind % 2) == 0 && size0 < 16) begin
          idx = (tail0 + $urandom_range(15 - size0)) % 16;
          if (!used[idx]) begin
            used[idx] = 1;
            cmpl_en[k] = 1'b1;
            cmpl_indx[k*4 +: 4] = 4'(idx);
            cmpl_pc[k*32 +: 32] = $urandom;
            cmpl_val[k*32 +: 32] = v;
            err_exp = 1;
          end
        end else begin
          cand.delete();
          for (int i = 0; i < sb_q.size(); i++)
            if (!sb_q[i].done && !used[sb_q[i].idx]) cand.push_back(i);
          if (cand.size() > 0) begin
            pos = cand[$urandom_range(cand.size() - 1)];
            e = sb_q[pos];
            used[e.idx] = 1;
            cmpl_en[k] = 1'b1;
            cmpl_indx[k*4 +: 4] = 4'(e.idx);
            cmpl_val[k*32 +: 32] = v;
            cmpl_pc[k*32 +: 32] = (kind < bp) ? (e.pc ^ 32'h4) : e.pc;
            if (fok && pos > p) begin
              // squashed in the same cycle: dropped without error
            end else if (kind < bp) begin
              err_exp = 1;
            end else begin
              e.val = v; e.done = 1; e.done_cyc = cyc;
              sb_q[pos] = e;
            end
          end
        end
      end
    end

    if (fl) begin
      if (fok) while (sb_q.size() > p + 1) void'(sb_q.pop_back());
      else err_exp = 1;
    end

    en_below = 0;
    for (int j = 0; j < 2; j++) begin
      disp_en[j] = ($urandom_range(99) < dp);
      disp_dest[j*6 +: 6] = 6'($urandom);
      disp_old_dest[j*6 +: 6] = 6'($urandom);
      disp_contr[j*5 +: 5] = 5'($urandom);
      disp_pc[j*32 +: 32] = {$urandom_range(32'h3fff_ffff), 2'b00};
      if (disp_en[j]) begin
        if (!fl && (16 - size0) >= 2) begin
          e.idx = (tail0 + en_below) % 16;
          e.pc = disp_pc[j*32 +: 32];
          e.dest = disp_dest[j*6 +: 6];
          e.old = disp_old_dest[j*6 +: 6];
          e.val = '0; e.done = 0; e.done_cyc = 0;
          sb_q.push_back(e);
        end
        en_below++;
      end
    end
    #1;
    check("disp_indx0", 64'(disp_indx[3:0]), 64'(tail0));
    check("disp_indx1", 64'(disp_indx[7:4]), 64'((tail0 + int'(disp_en[0])) % 16));
  endtask

  // Monitor: every retire lane the DUT presents must match the oldest expected entry.
  initial begin
    int         n;
    logic [1:0] mask_exp;
    ent_t       e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = 0;
        for (int r = 0; r < 2; r++)
          if (n == r && r < sb_q.size() && sb_q[r].done && sb_q[r].done_cyc < cyc) n++;
        mask_exp = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
        check("ret_en", 64'(ret_en), 64'(mask_exp));
        for (int r = 0; r < n; r++) begin
          e = sb_q.pop_front();
          m_head = (m_head + 1) % 16;
          check("ret_pc", 64'(ret_pc[r*32 +: 32]), 64'(e.pc));
          check("ret_val", 64'(ret_val[r*32 +: 32]), 64'(e.val));
          check("ret_dest", 64'(ret_dest[r*6 +: 6]), 64'(e.dest));
          check("ret_old_dest", 64'(ret_old_dest[r*6 +: 6]), 64'(e.old));
          $display("RET lane=%0d idx=%0d pc=%08h val=%08h", r, e.idx, e.pc, e.val);
        end
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0;
    clear_inputs();
    disp_en = 2'b11;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ready", 64'(disp_ready), 64'd1);
    check("rst_ret_en", 64'(ret_en), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_indx", 64'(disp_indx), 64'h10);
    disp_en = 2'b00;
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      if (i < 100)      do_cycle(80, 20, 3, 10);
      else if (i < 200) do_cycle(30, 70, 8, 10);
      else              do_cycle(60, 60, 5, 5);
    end

    // Mid-stream asynchronous reset with several live entries.
    budget = 40;
    while (sb_q.size() < 5 && budget > 0) begin
      do_cycle(90, 40, 0, 0);
      budget--;
    end
    @(posedge clk); #3;
    check("pre_rst_count", 64'(count), 64'(sb_q.size()));
    rst_n = 1'b0;
    clear_inputs();
    sb_q.delete();
    m_head = 0;
    err_exp = 0;
    #1;
    check("async_rst_ret_en", 64'(ret_en), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_empty", 64'(empty), 64'd1);
    check("async_rst_err", 64'(err), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) do_cycle(50, 50, 5, 10);

    budget = 200;
    while (sb_q.size() > 0 && budget > 0) begin
      do_cycle(0, 100, 0, 0);
      budget--;
    end
    do_cycle(0, 0, 0, 0);
    @(posedge clk); #1;
    check("drain_count", 64'(count), 64'd0);
    check("drain_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
